// File: rtl/march_bist.sv
// March C- memory BIST controller: sweeps every word of every bank with a
// six-element March sequence, then checks read data through a compare pipeline
// whose delay matches the memory read latency.
module march_bist #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned BANK_W = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       bist_start_i,
    input  logic                       bist_abort_i,
    input  logic [DATA_W-1:0]          bist_bg_i,
    input  logic [DATA_W-1:0]          mem_odata_i,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic                       mem_ce_o,
    output logic                       mem_web_o,
    output logic [(2**BANK_W)-1:0]     mem_csb_o,
    output logic [(2**BANK_W)-1:0]     mem_oeb_o,
    output logic [DATA_W-1:0]          mem_idata_o,
    output logic                       bist_busy_o,
    output logic                       bist_done_o,
    output logic                       bist_fail_o,
    output logic [BANK_W+ADDR_W-1:0]   fail_addr_o,
    output logic [DATA_W-1:0]          fail_exp_o,
    output logic [DATA_W-1:0]          fail_act_o,
    output logic [15:0]                fail_cnt_o
);

    localparam int unsigned LIN_W = BANK_W + ADDR_W;
    localparam int unsigned NB    = 2**BANK_W;
    localparam logic [LIN_W-1:0] LIN_MAX = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              phase_q, phase_d;
    logic [LIN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bg_q, bg_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ce_q, ce_d;
    logic              web_q, web_d;
    logic [NB-1:0]     csb_q, csb_d;
    logic [NB-1:0]     oeb_q, oeb_d;
    logic [DATA_W-1:0] idata_q, idata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [LIN_W-1:0]  faddr_q, faddr_d;
    logic [DATA_W-1:0] fexp_q, fexp_d;
    logic [DATA_W-1:0] fact_q, fact_d;
    logic [15:0]       fcnt_q, fcnt_d;

    logic [RD_LAT:0]             pv_q, pv_d;
    logic [RD_LAT:0][LIN_W-1:0]  pa_q, pa_d;
    logic [RD_LAT:0][DATA_W-1:0] pe_q, pe_d;

    logic              op_two, op_rd, op_down, op_last;
    logic [LIN_W-1:0]  op_a;
    logic [DATA_W-1:0] op_rdata, op_wdata;
    logic              cmp_en, mismatch, push, flush;

    // Decode the current March element/phase into address, direction and data.
    always_comb begin
        op_two   = (elem_q != 3'd0) && (elem_q != 3'd5);
        op_rd    = (elem_q == 3'd5) || (op_two && !phase_q);
        op_down  = (elem_q == 3'd3) || (elem_q == 3'd4);
        op_a     = op_down ? ~cnt_q : cnt_q;
        op_rdata = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~bg_q : bg_q;
        op_wdata = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~bg_q : bg_q;
        op_last  = (elem_q == 3'd5) && (cnt_q == LIN_MAX);
    end

    // Next-state, registered-output and compare logic.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bg_d    = bg_q;
        addr_d  = '0;
        ce_d    = 1'b0;
        web_d   = 1'b1;
        csb_d   = '1;
        oeb_d   = '1;
        idata_d = '0;
        busy_d  = busy_q;
        done_d  = done_q;
        fail_d  = fail_q;
        faddr_d = faddr_q;
        fexp_d  = fexp_q;
        fact_d  = fact_q;
        fcnt_d  = fcnt_q;
        push    = 1'b0;
        flush   = 1'b0;

        // Compare the oldest pipe entry against the returned read data.
        cmp_en   = pv_q[RD_LAT] && !bist_abort_i &&
                   ((state_q == S_RUN) || (state_q == S_DRAIN));
        mismatch = cmp_en && (mem_odata_i != pe_q[RD_LAT]);
        if (mismatch) begin
            fail_d = 1'b1;
            if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
            if (!fail_q) begin
                faddr_d = pa_q[RD_LAT];
                fexp_d  = pe_q[RD_LAT];
                fact_d  = mem_odata_i;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bist_start_i) begin
                    state_d = S_RUN;
                    elem_d  = 3'd0;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    bg_d    = bist_bg_i;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    faddr_d = '0;
                    fexp_d  = '0;
                    fact_d  = '0;
                    fcnt_d  = '0;
                end
            end
            S_RUN: begin
                ce_d   = 1'b1;
                addr_d = op_a[ADDR_W-1:0];
                csb_d  = ~(NB'(1) << op_a[LIN_W-1:ADDR_W]);
                if (op_rd) begin
                    oeb_d   = csb_d;
                    idata_d = idata_q;
                    push    = 1'b1;
                end else begin
                    web_d   = 1'b0;
                    idata_d = op_wdata;
                end
                if (op_two && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    cnt_d   = cnt_q + LIN_W'(1);
                    if (cnt_q == LIN_MAX) elem_d = elem_q + 3'd1;
                end
                if (op_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Last read sits in the final stage; it is compared this edge.
                if (~|pv_q[RD_LAT-1:0]) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bist_abort_i) begin
            state_d = S_IDLE;
            addr_d  = '0;
            ce_d    = 1'b0;
            web_d   = 1'b1;
            csb_d   = '1;
            oeb_d   = '1;
            idata_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            push    = 1'b0;
            flush   = 1'b1;
        end

        pv_d = flush ? '0 : {pv_q[RD_LAT-1:0], push};
        pa_d = {pa_q[RD_LAT-1:0], op_a};
        pe_d = {pe_q[RD_LAT-1:0], op_rdata};
    end

    // State, output and compare-pipe registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            elem_q  <= 3'd0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            bg_q    <= '0;
            addr_q  <= '0;
            ce_q    <= 1'b0;
            web_q   <= 1'b1;
            csb_q   <= '1;
            oeb_q   <= '1;
            idata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            faddr_q <= '0;
            fexp_q  <= '0;
            fact_q  <= '0;
            fcnt_q  <= '0;
            pv_q    <= '0;
            pa_q    <= '0;
            pe_q    <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bg_q    <= bg_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
            web_q   <= web_d;
            csb_q   <= csb_d;
            oeb_q   <= oeb_d;
            idata_q <= idata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            faddr_q <= faddr_d;
            fexp_q  <= fexp_d;
            fact_q  <= fact_d;
            fcnt_q  <= fcnt_d;
            pv_q    <= pv_d;
            pa_q    <= pa_d;
            pe_q    <= pe_d;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_ce_o    = ce_q;
    assign mem_web_o   = web_q;
    assign mem_csb_o   = csb_q;
    assign mem_oeb_o   = oeb_q;
    assign mem_idata_o = idata_q;
    assign bist_busy_o = busy_q;
    assign bist_done_o = done_q;
    assign bist_fail_o = fail_q;
    assign fail_addr_o = faddr_q;
    assign fail_exp_o  = fexp_q;
    assign fail_act_o  = fact_q;
    assign fail_cnt_o  = fcnt_q;

endmodule

// File: tb/tb_march_bist.sv
// Bench for march_bist: two instances (read latency 1 and 3) on a 2-bank x
// 4-word memory model, with an optional bank1/word2 bit0 stuck-at-0 fault.
module tb_march_bist;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] bg = 8'h00;
    logic       fault = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic [7:0] od1, id1, fe1, fac1;
    logic [1:0] a1, csb1, oeb1;
    logic       ce1, web1, busy1, done1, fail1;
    logic [2:0] fa1;
    logic [15:0] fc1;

    logic [7:0] od3, id3, fe3, fac3;
    logic [1:0] a3, csb3, oeb3;
    logic       ce3, web3, busy3, done3, fail3;
    logic [2:0] fa3;
    logic [15:0] fc3;

    march_bist #(.ADDR_W(2), .BANK_W(1), .DATA_W(8), .RD_LAT(1)) u1 (
        .clk_i(clk), .rstn_i(rstn), .bist_start_i(start), .bist_abort_i(abort),
        .bist_bg_i(bg), .mem_odata_i(od1), .mem_addr_o(a1), .mem_ce_o(ce1),
        .mem_web_o(web1), .mem_csb_o(csb1), .mem_oeb_o(oeb1), .mem_idata_o(id1),
        .bist_busy_o(busy1), .bist_done_o(done1), .bist_fail_o(fail1),
        .fail_addr_o(fa1), .fail_exp_o(fe1), .fail_act_o(fac1), .fail_cnt_o(fc1)
    );

    march_bist #(.ADDR_W(2), .BANK_W(1), .DATA_W(8), .RD_LAT(3)) u3 (
        .clk_i(clk), .rstn_i(rstn), .bist_start_i(start), .bist_abort_i(abort),
        .bist_bg_i(bg), .mem_odata_i(od3), .mem_addr_o(a3), .mem_ce_o(ce3),
        .mem_web_o(web3), .mem_csb_o(csb3), .mem_oeb_o(oeb3), .mem_idata_o(id3),
        .bist_busy_o(busy3), .bist_done_o(done3), .bist_fail_o(fail3),
        .fail_addr_o(fa3), .fail_exp_o(fe3), .fail_act_o(fac3), .fail_cnt_o(fc3)
    );

    // Memory models: bank index is the csb bit that is low (bit1 low -> bank1).
    logic [7:0] mem1 [8];
    logic [7:0] mem3 [8];
    logic [7:0] r3 [3];

    function automatic logic [7:0] flt(input logic [2:0] la, input logic [7:0] v);
        return (fault && la == 3'd6) ? (v & 8'hFE) : v;
    endfunction

    always @(posedge clk) begin
        if (ce1) begin
            if (!web1) mem1[{csb1[0], a1}] <= id1;
            else       od1 <= flt({csb1[0], a1}, mem1[{csb1[0], a1}]);
        end
        if (ce3) begin
            if (!web3) mem3[{csb3[0], a3}] <= id3;
            else       r3[0] <= flt({csb3[0], a3}, mem3[{csb3[0], a3}]);
        end
        r3[1] <= r3[0];
        r3[2] <= r3[1];
    end
    assign od3 = r3[2];

    // Results collected by run_pass.
    int op_err, ce_cnt, csb_err, done_c1, done_c3, fail_c1, fail_c3, bad_c;

    // Expected op i of the 80-op March C- stream for N=8.
    task automatic exp_op(input int i, input logic [7:0] bgv,
                          output logic rd, output logic [2:0] la, output logic [7:0] d);
        int e, k, cn;
        if (i < 8) begin
            e = 0; rd = 1'b0; cn = i;
        end else if (i < 72) begin
            e = 1 + (i - 8) / 16; k = (i - 8) % 16; cn = k / 2; rd = (k % 2 == 0);
        end else begin
            e = 5; rd = 1'b1; cn = i - 72;
        end
        la = (e == 3 || e == 4) ? 3'(7 - cn) : 3'(cn);
        if (rd) d = (e == 2 || e == 4) ? ~bgv : bgv;
        else    d = (e == 1 || e == 3) ? ~bgv : bgv;
    endtask

    // Start a run and follow it cycle by cycle (c = cycles after the START edge).
    task automatic run_pass(input logic [7:0] bgv, input int start2_c, input int stop_c);
        logic rd;
        logic [2:0] la;
        logic [7:0] d, lw, eid;
        logic [1:0] ecsb, eoeb, eaddr;
        logic ece, eweb;
        op_err = 0; ce_cnt = 0; csb_err = 0; bad_c = -1;
        done_c1 = -1; done_c3 = -1; fail_c1 = -1; fail_c3 = -1;
        lw = 8'h00;
        @(negedge clk); start = 1'b1; bg = bgv;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (c >= 1 && c <= 80) begin
                exp_op(c - 1, bgv, rd, la, d);
                ece = 1'b1; eweb = rd; eaddr = la[1:0];
                ecsb = la[2] ? 2'b01 : 2'b10;
                eoeb = rd ? ecsb : 2'b11;
                eid = rd ? lw : d;
                if (!rd) lw = d;
            end else begin
                ece = 1'b0; eweb = 1'b1; eaddr = 2'b00;
                ecsb = 2'b11; eoeb = 2'b11; eid = 8'h00;
            end
            if ({ce1, web1, a1, csb1, oeb1, id1} !== {ece, eweb, eaddr, ecsb, eoeb, eid} ||
                {ce3, web3, a3, csb3, oeb3, id3} !== {ece, eweb, eaddr, ecsb, eoeb, eid}) begin
                op_err++;
                if (bad_c < 0) bad_c = c;
            end
            if (ce1 === 1'b1) ce_cnt++;
            if (csb1 === 2'b00 || csb3 === 2'b00) csb_err++;
            if (done1 === 1'b1 && done_c1 < 0) done_c1 = c;
            if (done3 === 1'b1 && done_c3 < 0) done_c3 = c;
            if (fail1 === 1'b1 && fail_c1 < 0) fail_c1 = c;
            if (fail3 === 1'b1 && fail_c3 < 0) fail_c3 = c;
            if (c == stop_c) return;
            if (done_c1 >= 0 && done_c3 >= 0) return;
            start = (c == start2_c);
            if (c == start2_c) bg = ~bgv;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ce1, web1, csb1, oeb1, a1, id1, busy1, done1, fail1, fa1, fe1, fac1, fc1} !==
            {1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 8'h00, 3'b000, 3'b000, 8'h00, 8'h00, 16'h0000}) begin
            n_err++; $display("FAIL reset_u1: ce=%b web=%b csb=%b oeb=%b busy=%b done=%b fail=%b cnt=%h", ce1, web1, csb1, oeb1, busy1, done1, fail1, fc1);
        end
        n_vec++;
        if ({ce3, web3, csb3, oeb3, a3, id3, busy3, done3, fail3, fa3, fe3, fac3, fc3} !==
            {1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 8'h00, 3'b000, 3'b000, 8'h00, 8'h00, 16'h0000}) begin
            n_err++; $display("FAIL reset_u3: ce=%b web=%b csb=%b oeb=%b busy=%b done=%b fail=%b cnt=%h", ce3, web3, csb3, oeb3, busy3, done3, fail3, fc3);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        fault = 1'b0;
        run_pass(8'h00, -1, -1);
        n_vec++; if (op_err !== 0) begin n_err++; $display("FAIL clean_ops: %0d bad cycles, first at %0d, want 0", op_err, bad_c); end
        n_vec++; if (done_c1 !== 82) begin n_err++; $display("FAIL clean_done_lat1: cycle %0d want 82", done_c1); end
        n_vec++; if (done_c3 !== 84) begin n_err++; $display("FAIL clean_done_lat3: cycle %0d want 84", done_c3); end
        n_vec++; if (ce_cnt !== 80) begin n_err++; $display("FAIL clean_ce_count: %0d want 80", ce_cnt); end
        n_vec++; if (csb_err !== 0) begin n_err++; $display("FAIL clean_csb_onehot: %0d cycles with two banks low", csb_err); end
        n_vec++; if ({busy1, fail1, fc1, busy3, fail3, fc3} !== 36'h0) begin
            n_err++; $display("FAIL clean_status: busy1=%b fail1=%b cnt1=%h busy3=%b fail3=%b cnt3=%h want all 0", busy1, fail1, fc1, busy3, fail3, fc3); end
    endtask

    task automatic test_stuck_at();
        fault = 1'b1;
        run_pass(8'h00, -1, -1);
        n_vec++; if ({fail1, fa1, fe1, fac1, fc1} !== {1'b1, 3'd6, 8'hFF, 8'hFE, 16'd2}) begin
            n_err++; $display("FAIL stuck_u1: fail=%b addr=%0d exp=%h act=%h cnt=%0d want 1/6/ff/fe/2", fail1, fa1, fe1, fac1, fc1); end
        n_vec++; if ({fail3, fa3, fe3, fac3, fc3} !== {1'b1, 3'd6, 8'hFF, 8'hFE, 16'd2}) begin
            n_err++; $display("FAIL stuck_u3: fail=%b addr=%0d exp=%h act=%h cnt=%0d want 1/6/ff/fe/2", fail3, fa3, fe3, fac3, fc3); end
        n_vec++; if (fail_c1 !== 39) begin n_err++; $display("FAIL stuck_first_lat1: cycle %0d want 39", fail_c1); end
        n_vec++; if (fail_c3 !== 41) begin n_err++; $display("FAIL stuck_first_lat3: cycle %0d want 41", fail_c3); end
        n_vec++; if (done_c1 !== 82) begin n_err++; $display("FAIL stuck_done: cycle %0d want 82", done_c1); end
    endtask

    task automatic test_bg_a5();
        fault = 1'b0;
        run_pass(8'hA5, -1, -1);
        n_vec++; if (op_err !== 0) begin n_err++; $display("FAIL a5_ops: %0d bad cycles, first at %0d, want 0", op_err, bad_c); end
        n_vec++; if (done_c3 !== 84) begin n_err++; $display("FAIL a5_done_lat3: cycle %0d want 84", done_c3); end
        n_vec++; if ({fail1, fc1, fail3, fc3} !== 34'h0) begin
            n_err++; $display("FAIL a5_status: fail1=%b cnt1=%h fail3=%b cnt3=%h want 0", fail1, fc1, fail3, fc3); end
    endtask

    task automatic test_abort();
        fault = 1'b0;
        run_pass(8'h00, -1, 31);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++; if ({ce1, web1, csb1, oeb1, a1, id1, busy1, done1} !== {1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 8'h00, 2'b00}) begin
            n_err++; $display("FAIL abort_u1: ce=%b csb=%b oeb=%b busy=%b done=%b want idle", ce1, csb1, oeb1, busy1, done1); end
        n_vec++; if ({ce3, web3, csb3, oeb3, a3, id3, busy3, done3} !== {1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 8'h00, 2'b00}) begin
            n_err++; $display("FAIL abort_u3: ce=%b csb=%b oeb=%b busy=%b done=%b want idle", ce3, csb3, oeb3, busy3, done3); end
        repeat (3) @(negedge clk);
        n_vec++; if ({ce1, done1, ce3, done3} !== 4'b0000) begin
            n_err++; $display("FAIL abort_stays_idle: ce1=%b done1=%b ce3=%b done3=%b", ce1, done1, ce3, done3); end
        run_pass(8'h00, -1, -1);
        n_vec++; if (op_err !== 0 || done_c1 !== 82 || fc1 !== 16'd0 || fc3 !== 16'd0) begin
            n_err++; $display("FAIL abort_rerun: op_err=%0d done=%0d cnt1=%0d cnt3=%0d want 0/82/0/0", op_err, done_c1, fc1, fc3); end
    endtask

    task automatic test_reset_mid();
        fault = 1'b0;
        run_pass(8'h3C, -1, 45);
        #2 rstn = 1'b0;
        #1;
        n_vec++; if ({ce1, web1, csb1, oeb1, busy1, ce3, csb3, busy3} !== {1'b0, 1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0}) begin
            n_err++; $display("FAIL reset_mid_async: ce1=%b csb1=%b busy1=%b ce3=%b busy3=%b want idle", ce1, csb1, busy1, ce3, busy3); end
        @(negedge clk);
        rstn = 1'b1;
        run_pass(8'h3C, -1, -1);
        n_vec++; if (op_err !== 0 || done_c1 !== 82 || done_c3 !== 84) begin
            n_err++; $display("FAIL reset_mid_rerun: op_err=%0d first=%0d done1=%0d done3=%0d want 0/82/84", op_err, bad_c, done_c1, done_c3); end
    endtask

    task automatic test_back_to_back();
        fault = 1'b1;
        run_pass(8'h00, 20, -1);
        n_vec++; if (op_err !== 0) begin n_err++; $display("FAIL busy_start_ops: %0d bad cycles, first at %0d, want 0", op_err, bad_c); end
        n_vec++; if ({fail1, fc1, done_c1} !== {1'b1, 16'd2, 32'd82}) begin
            n_err++; $display("FAIL busy_start_result: fail=%b cnt=%0d done=%0d want 1/2/82", fail1, fc1, done_c1); end
        fault = 1'b0;
        run_pass(8'h00, -1, -1);
        n_vec++; if ({fail1, fa1, fe1, fac1, fc1} !== 36'h0) begin
            n_err++; $display("FAIL rerun_clear_u1: fail=%b addr=%0d exp=%h act=%h cnt=%0d want 0", fail1, fa1, fe1, fac1, fc1); end
        n_vec++; if ({fail3, fa3, fe3, fac3, fc3} !== 36'h0) begin
            n_err++; $display("FAIL rerun_clear_u3: fail=%b addr=%0d exp=%h act=%h cnt=%0d want 0", fail3, fa3, fe3, fac3, fc3); end
        n_vec++; if (done_c1 !== 82 || done_c3 !== 84) begin
            n_err++; $display("FAIL rerun_done: done1=%0d done3=%0d want 82/84", done_c1, done_c3); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stuck_at();
        test_bg_a5();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/march_bist.md
# march_bist

Parametrised March C- memory built-in self-test controller for the banked SRAM array behind the memory controller. It sweeps every word of every bank with a fixed six-element March sequence, driving the same chip-enable, write-enable, bank-select and output-enable strobes as functional traffic. Read data is compared through a latency-matched pipeline. The block reports busy/done, a sticky fail flag, first-failure capture and a saturating mismatch count.

## Interface
- ADDR_W, 10: word-address width per bank.
- BANK_W, 6: bank-select width; bank count NB = 2^BANK_W.
- DATA_W, 8: memory data width.
- RD_LAT, 1: cycles from read strobe (memory sampling edge) to MEM_ODATA valid; legal 1..4.
- CLK  in  1  single clock; all state on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- BIST_START  in  1  start pulse; honoured only when BIST_BUSY=0.
- BIST_ABORT  in  1  stop run; wins over BIST_START.
- BIST_BG  in  DATA_W  background pattern, sampled with BIST_START.
- MEM_ODATA  in  DATA_W  read data from selected bank.
- MEM_ADDR  out  ADDR_W  word address within bank.
- MEM_CE  out  1  access strobe, high during every test op.
- MEM_WEB  out  1  active-low write enable.
- MEM_CSB  out  NB  active-low one-hot bank select.
- MEM_OEB  out  NB  active-low output enable; low on reads only.
- MEM_IDATA  out  DATA_W  write data.
- BIST_BUSY  out  1  run in progress.
- BIST_DONE  out  1  run completed without abort; held until next start.
- BIST_FAIL  out  1  sticky: at least one mismatch this run.
- FAIL_ADDR  out  BANK_W+ADDR_W  linear address {bank,word} of first mismatch.
- FAIL_EXP  out  DATA_W  expected data at first mismatch.
- FAIL_ACT  out  DATA_W  actual data at first mismatch.
- FAIL_CNT  out  16  mismatch count; saturates at 16'hFFFF.

## Operation
- Linear address A = {bank, word}, N = 2^(BANK_W+ADDR_W). D0 = BG (latched), D1 = ~BG.
- Sequence: M0 ⇑(w D0); M1 ⇑(r D0, w D1); M2 ⇑(r D1, w D0); M3 ⇓(r D0, w D1); M4 ⇓(r D1, w D0); M5 ⇑(r D0). ⇑ = 0..N-1, ⇓ = N-1..0. Total 10N ops.
- FSM: IDLE -> RUN on START (no ABORT); RUN -> DRAIN after last op issued; DRAIN -> DONE once the last read is compared; DONE -> RUN on START; any state -> IDLE on ABORT.
- Op encoding: write = CE=1, WEB=0, CSB bit[bank]=0, OEB all 1, IDATA = pattern. Read = CE=1, WEB=1, CSB and OEB bit[bank]=0, IDATA holds its last value.
- Idle/DONE/DRAIN outputs: CE=0, WEB=1, CSB/OEB all ones, ADDR=0, IDATA=0.
- Compare pipe depth RD_LAT+1 carries valid, A and expected data.
  - Mismatch increments FAIL_CNT (saturating) and sets BIST_FAIL.
  - First mismatch of a run loads FAIL_ADDR/EXP/ACT; later mismatches leave them frozen.
- START clears FAIL, CNT, FAIL_* and DONE, and latches BG. START while busy is ignored.

## Timing
- Reset: state IDLE; all outputs at idle values; BUSY, DONE, FAIL=0; FAIL_ADDR, FAIL_EXP, FAIL_ACT, FAIL_CNT = 0; pipe cleared. Reset mid-run aborts immediately with no memory strobe after RSTN falls.
- All outputs are registered. START sampled at edge e0 gives BUSY=1 after e0. Op i is driven after edge e0+1+i, one op per cycle, with no bubbles between elements or reads/writes.
- Read issued after edge t: memory samples it at t+1; compare at edge t+1+RD_LAT.
- Last op is driven after e0+10N. DONE=1 and BUSY=0 after edge e0+10N+1+RD_LAT; the final compare result is visible in the same cycle.
- ABORT sampled at edge: idle outputs after that edge, in-flight compares discarded, DONE stays 0, fail status is kept.
- Read-then-write to the same address occurs on consecutive cycles; the memory is required to support this.

## Test plan
- ADDR_W=2, BANK_W=1, RD_LAT=1, BG=8'h00, fault-free model -> DONE exactly 82 cycles after START edge, FAIL=0, CNT=0, 80 CE-high cycles, CSB never has two bits low.
- Same config, bank1 word2 bit0 stuck-at-0 -> FAIL=1, FAIL_ADDR=6, EXP=8'hFF, ACT=8'hFE (captured in M2), CNT=2.
- BG=8'hA5, RD_LAT=3 model, fault-free -> all writes alternate 8'hA5/8'h5A per element, DONE at cycle 84, FAIL=0.
- ABORT raised at op 30 -> idle outputs the next cycle, BUSY=0, DONE=0. A following START runs a full clean pass with CNT=0.
- RSTN pulled low mid-M3 -> outputs at reset values asynchronously. START after release runs the full sequence from M0.
- START pulsed again while BUSY, plus a second run after DONE with a fault removed -> first pulse ignored; second run clears FAIL/FAIL_* and ends with FAIL=0.
